// File: rtl/quad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : quad_pkg
// Description : Shared widths, default gains and FSM encoding for the
//               quadrature sample scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package quad_pkg;

    localparam int POS_W      = 32;
    localparam int SEQ_W      = 16;
    localparam int K0_DEFAULT = 225;
    localparam int K1_DEFAULT = 424;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        VEL   = 3'd2,
        DISP0 = 3'd3,
        DISP1 = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/quad_sample_timer.sv
`default_nettype none
// ============================================================================
// Module      : quad_sample_timer
// Description : Sample-period counter; pulses tick on the terminal count
//               and parks at zero while sampling is disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module quad_sample_timer #(
    parameter int SAMPLE_TICKS = 50_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int                 c_CNT_W = $clog2(SAMPLE_TICKS);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(SAMPLE_TICKS - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign tick = enable && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/quad_sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : quad_sample_scheduler
// Description : Snapshots all encoder counts on a common trigger and
//               sequences one subtractor and one multiplier to produce
//               per-channel velocity and tendon displacement.
// Revision    : 1.0 - initial release
// ============================================================================
module quad_sample_scheduler
    import quad_pkg::*;
#(
    parameter int NUM_ENC      = 2,
    parameter int SAMPLE_TICKS = 50_000,
    parameter int K0           = K0_DEFAULT,
    parameter int K1           = K1_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       sample_req,
    input  logic                       zero_req,
    input  logic                       overrun_clr,
    input  logic [NUM_ENC*POS_W-1:0]   pos_flat,
    output logic [NUM_ENC*POS_W-1:0]   snap_flat,
    output logic [NUM_ENC*POS_W-1:0]   vel_flat,
    output logic [POS_W-1:0]           displacement,
    output logic                       sample_valid,
    output logic                       busy,
    output logic                       overrun,
    output logic [SEQ_W-1:0]           sample_seq
);

    localparam int                 c_IDX_W    = (NUM_ENC > 1) ? $clog2(NUM_ENC) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_ENC - 1);
    localparam logic [POS_W-1:0]   c_K0       = POS_W'(K0);
    localparam logic [POS_W-1:0]   c_K1       = POS_W'(K1);

    state_t               r_state;
    state_t               w_next;
    logic [c_IDX_W-1:0]   r_idx;
    logic [POS_W-1:0]     r_snap     [NUM_ENC];
    logic [POS_W-1:0]     r_prev     [NUM_ENC];
    logic [POS_W-1:0]     r_vel      [NUM_ENC];
    logic [POS_W-1:0]     r_snap_out [NUM_ENC];
    logic [POS_W-1:0]     r_vel_out  [NUM_ENC];
    logic [POS_W-1:0]     r_off0;
    logic [POS_W-1:0]     r_off1;
    logic [POS_W-1:0]     r_acc;
    logic [POS_W-1:0]     r_disp;
    logic                 r_valid;
    logic                 r_first;
    logic                 r_zero_pending;
    logic                 r_overrun;
    logic [SEQ_W-1:0]     r_seq;

    logic                 w_tick;
    logic                 w_trigger;
    logic                 w_busy;
    logic [POS_W-1:0]     w_pos [NUM_ENC];
    logic [POS_W-1:0]     w_sub_a;
    logic [POS_W-1:0]     w_sub_b;
    logic [POS_W-1:0]     w_k;
    logic [POS_W-1:0]     w_diff;
    logic [POS_W-1:0]     w_prod;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ENC; gi++) begin : g_chan
            assign w_pos[gi]                      = pos_flat[gi*POS_W +: POS_W];
            assign snap_flat[gi*POS_W +: POS_W]   = r_snap_out[gi];
            assign vel_flat[gi*POS_W +: POS_W]    = r_vel_out[gi];
        end
    endgenerate

    quad_sample_timer #(
        .SAMPLE_TICKS (SAMPLE_TICKS)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (w_tick)
    );

    assign w_busy    = (r_state != IDLE);
    assign w_trigger = w_tick | sample_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_trigger) w_next = LATCH;
            LATCH:   w_next = VEL;
            VEL:     if (r_idx == c_LAST_IDX) w_next = DISP0;
            DISP0:   w_next = DISP1;
            DISP1:   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // One subtractor serves velocity (snap - prev) and zeroed position (snap - off).
    always_comb begin
        w_sub_a = r_snap[r_idx];
        w_sub_b = r_prev[r_idx];
        w_k     = c_K0;
        case (r_state)
            DISP0: begin
                w_sub_a = r_snap[0];
                w_sub_b = r_off0;
            end
            DISP1: begin
                w_sub_a = r_snap[1];
                w_sub_b = r_off1;
                w_k     = c_K1;
            end
            default: ;
        endcase
    end

    assign w_diff = w_sub_a - w_sub_b;
    assign w_prod = w_diff * w_k;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx          <= '0;
            r_off0         <= '0;
            r_off1         <= '0;
            r_acc          <= '0;
            r_disp         <= '0;
            r_valid        <= 1'b0;
            r_first        <= 1'b1;
            r_zero_pending <= 1'b0;
            r_overrun      <= 1'b0;
            r_seq          <= '0;
            for (int i = 0; i < NUM_ENC; i++) begin
                r_snap[i]     <= '0;
                r_prev[i]     <= '0;
                r_vel[i]      <= '0;
                r_snap_out[i] <= '0;
                r_vel_out[i]  <= '0;
            end
        end else begin
            r_valid <= 1'b0;

            // A request landing in LATCH survives to the following snapshot.
            if (zero_req) begin
                r_zero_pending <= 1'b1;
            end else if (r_state == LATCH) begin
                r_zero_pending <= 1'b0;
            end

            if (w_trigger && w_busy) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end

            case (r_state)
                LATCH: begin
                    r_idx <= '0;
                    for (int i = 0; i < NUM_ENC; i++) begin
                        r_snap[i] <= w_pos[i];
                    end
                    if (r_zero_pending) begin
                        r_off0 <= w_pos[0];
                        r_off1 <= w_pos[1];
                    end
                end
                VEL: begin
                    r_vel[r_idx]  <= r_first ? '0 : w_diff;
                    r_prev[r_idx] <= r_snap[r_idx];
                    r_idx         <= r_idx + c_IDX_W'(1);
                end
                DISP0: begin
                    r_acc <= w_prod;
                end
                // Commit on entry to DONE so results and the valid pulse appear together.
                DISP1: begin
                    r_disp  <= r_acc - w_prod;
                    r_valid <= 1'b1;
                    r_seq   <= r_seq + SEQ_W'(1);
                    r_first <= 1'b0;
                    for (int i = 0; i < NUM_ENC; i++) begin
                        r_snap_out[i] <= r_snap[i];
                        r_vel_out[i]  <= r_vel[i];
                    end
                end
                default: ;
            endcase
        end
    end

    assign displacement = r_disp;
    assign sample_valid = r_valid;
    assign busy         = w_busy;
    assign overrun      = r_overrun;
    assign sample_seq   = r_seq;

endmodule
`default_nettype wire

// File: tb/tb_quad_sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_quad_sample_scheduler
// Description : Scoreboard bench: a cycle model pushes expected results at
//               snapshot time and pops them when the DONE cycle is reached.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quad_sample_scheduler;

    localparam int c_NUM_ENC = 2;
    localparam int c_TICKS   = 16;
    localparam int c_K0      = 225;
    localparam int c_K1      = 424;
    localparam int c_DONE_PH = c_NUM_ENC + 4;

    typedef struct {
        logic [63:0] snap;
        logic [63:0] vel;
        logic [31:0] disp;
        logic [15:0] seq;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic               sample_req;
    logic               zero_req;
    logic               overrun_clr;
    logic signed [31:0] p0;
    logic signed [31:0] p1;
    logic [63:0]        pos_flat;
    logic [63:0]        snap_flat;
    logic [63:0]        vel_flat;
    logic [31:0]        displacement;
    logic               sample_valid;
    logic               busy;
    logic               overrun;
    logic [15:0]        sample_seq;

    exp_t        sb_q[$];
    exp_t        m_out;
    int          m_cnt;
    int          m_phase;
    int          m_prev[2];
    int          m_off[2];
    bit          m_first;
    bit          m_zero_pend;
    bit          m_overrun;
    bit          m_known = 1'b0;
    logic [15:0] m_seq;
    int          n_chk  = 0;
    int          n_fail = 0;

    assign pos_flat = {p1, p0};

    always #5 clk = ~clk;

    quad_sample_scheduler #(
        .NUM_ENC      (c_NUM_ENC),
        .SAMPLE_TICKS (c_TICKS),
        .K0           (c_K0),
        .K1           (c_K1)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sample_req   (sample_req),
        .zero_req     (zero_req),
        .overrun_clr  (overrun_clr),
        .pos_flat     (pos_flat),
        .snap_flat    (snap_flat),
        .vel_flat     (vel_flat),
        .displacement (displacement),
        .sample_valid (sample_valid),
        .busy         (busy),
        .overrun      (overrun),
        .sample_seq   (sample_seq)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Cycle model: compare current outputs, then advance to the next cycle.
    always @(negedge clk) begin : model
        exp_t e;
        logic ev;
        int   q0, q1, v0, v1;
        logic tick, trig;
        if (m_known) begin
            ev = (m_phase == c_DONE_PH);
            if (ev) begin
                if (sb_q.size() == 0) check_eq("sb_empty", 64'd1, 64'd0);
                else m_out = sb_q.pop_front();
            end
            check_eq("valid", sample_valid, ev);
            check_eq("busy", busy, m_phase != 0);
            check_eq("overrun", overrun, m_overrun);
            check_eq("snap", snap_flat, m_out.snap);
            check_eq("vel", vel_flat, m_out.vel);
            check_eq("disp", displacement, m_out.disp);
            check_eq("seq", sample_seq, m_out.seq);
        end
        if (reset) begin
            sb_q.delete();
            m_out       = '{64'd0, 64'd0, 32'd0, 16'd0};
            m_cnt       = 0;
            m_phase     = 0;
            m_prev      = '{0, 0};
            m_off       = '{0, 0};
            m_first     = 1'b1;
            m_zero_pend = 1'b0;
            m_overrun   = 1'b0;
            m_seq       = '0;
            m_known     = 1'b1;
        end else if (m_known) begin
            tick = enable && (m_cnt == c_TICKS - 1);
            trig = tick || sample_req;
            if (m_phase == 1) begin
                q0 = p0;
                q1 = p1;
                if (m_zero_pend) begin
                    m_off[0]    = q0;
                    m_off[1]    = q1;
                    m_zero_pend = 1'b0;
                end
                v0 = m_first ? 0 : q0 - m_prev[0];
                v1 = m_first ? 0 : q1 - m_prev[1];
                m_prev[0] = q0;
                m_prev[1] = q1;
                m_first   = 1'b0;
                m_seq     = m_seq + 16'd1;
                e.snap = {q1, q0};
                e.vel  = {v1, v0};
                e.disp = c_K0 * (q0 - m_off[0]) - c_K1 * (q1 - m_off[1]);
                e.seq  = m_seq;
                sb_q.push_back(e);
            end
            if (zero_req) m_zero_pend = 1'b1;
            if (trig && m_phase != 0) m_overrun = 1'b1;
            else if (overrun_clr) m_overrun = 1'b0;
            if (m_phase == 0) m_phase = trig ? 1 : 0;
            else m_phase = (m_phase == c_DONE_PH) ? 0 : m_phase + 1;
            if (!enable || m_cnt == c_TICKS - 1) m_cnt = 0;
            else m_cnt = m_cnt + 1;
        end
    end

    task automatic wait_valid(input int max_cycles);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_valid && n < max_cycles);
        check_eq("valid_seen", sample_valid, 1'b1);
    endtask

    // Returns at the falling edge inside the LATCH cycle of a fresh sequence.
    task automatic wait_start(input int max_cycles);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < max_cycles);
        do begin
            @(negedge clk);
            n++;
        end while (!busy && n < max_cycles);
        check_eq("start_seen", busy, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        reset       = 1'b1;
        enable      = 1'b0;
        sample_req  = 1'b0;
        zero_req    = 1'b0;
        overrun_clr = 1'b0;
        p0          = 32'sd100;
        p1          = 32'sd50;
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        enable = 1'b1;

        wait_valid(40);
        check_eq("s1_vel", vel_flat, 64'd0);
        check_eq("s1_disp", displacement, 64'd1300);
        check_eq("s1_seq", sample_seq, 64'd1);

        @(posedge clk); #1;
        p0 = 32'sd110;
        p1 = 32'sd45;
        wait_valid(40);
        check_eq("s2_vel", vel_flat, {32'hFFFF_FFFB, 32'd10});
        check_eq("s2_disp", displacement, 64'd5670);
        check_eq("s2_seq", sample_seq, 64'd2);

        repeat (4) @(posedge clk);
        #1 zero_req = 1'b1;
        @(posedge clk);
        #1 zero_req = 1'b0;
        wait_valid(40);
        check_eq("zero_disp", displacement, 64'd0);
        check_eq("zero_vel", vel_flat, 64'd0);
        @(posedge clk); #1;
        p0 = 32'sd111;
        wait_valid(40);
        check_eq("zero_next_disp", displacement, 64'd225);
        check_eq("zero_next_vel", vel_flat, {32'd0, 32'd1});

        @(posedge clk); #1;
        p0 = 32'h7FFF_FFFF;
        wait_valid(40);
        @(posedge clk); #1;
        p0 = 32'h8000_0000;
        wait_valid(40);
        check_eq("wrap_vel0", vel_flat[31:0], 64'd1);

        wait_start(40);
        @(posedge clk);
        #1 sample_req = 1'b1;
        @(posedge clk);
        #1 sample_req = 1'b0;
        wait_valid(20);
        check_eq("ovr_set", overrun, 1'b1);
        repeat (20) @(negedge clk);
        check_eq("ovr_sticky", overrun, 1'b1);
        @(posedge clk);
        #1 overrun_clr = 1'b1;
        @(posedge clk);
        #1 overrun_clr = 1'b0;
        @(negedge clk);
        check_eq("ovr_clr", overrun, 1'b0);

        // sample_req exactly on the tick cycle must start a single sequence.
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while ((m_cnt != c_TICKS - 1 || busy) && n < 40);
        sample_req = 1'b1;
        @(posedge clk);
        #1 sample_req = 1'b0;
        wait_valid(20);
        check_eq("coinc_ovr", overrun, 1'b0);

        wait_start(40);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("rst_valid", sample_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_disp", displacement, 64'd0);
        check_eq("rst_snap", snap_flat, 64'd0);
        check_eq("rst_seq", sample_seq, 64'd0);
        wait_valid(40);
        check_eq("post_rst_vel", vel_flat, 64'd0);
        check_eq("post_rst_seq", sample_seq, 64'd1);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/quad_sample_scheduler.md
Name: quad_sample_scheduler

Overview:
Periodic sampling controller for the quadrature encoder counters of one myo muscle unit. It snapshots all encoder positions on a common tick and sequences one shared subtractor and one shared multiplier to produce per-encoder velocity and a tendon displacement value. It also applies zeroing offsets, and presents results with a valid pulse to the Avalon register block. It sits between the quad counter instances and the bus-facing register module.

Parameters:
NUM_ENC, 2, number of encoder channels (2..8); channels 0 and 1 feed displacement
SAMPLE_TICKS, 50_000, clock cycles per sample period (1 kHz at 50 MHz); must be >= NUM_ENC+5
K0, 225, signed displacement gain for channel 0
K1, 424, signed displacement gain for channel 1

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  periodic sampling enable
sample_req  in  1  one-cycle pulse: request an immediate sample
zero_req  in  1  one-cycle pulse: capture zeroing offsets at the next snapshot
overrun_clr  in  1  clears the sticky overrun flag
pos_flat  in  NUM_ENC*32  signed raw counts; channel i in bits [32i+31:32i]
snap_flat  out  NUM_ENC*32  latched positions of the last completed sample
vel_flat  out  NUM_ENC*32  signed count delta per sample, one per channel
displacement  out  32  signed K0*(snap0-off0) - K1*(snap1-off1)
sample_valid  out  1  one-cycle pulse when all outputs update
busy  out  1  high while a sample sequence is in progress
overrun  out  1  sticky: a trigger arrived while busy
sample_seq  out  16  completed-sample counter, wraps at 65535->0

Behaviour:
- Reset (sync, active-high): state IDLE, period counter 0, all outputs 0, offsets 0, first_sample=1, zero_pending=0. Reset mid-sequence aborts it; no sample_valid is emitted.
- Period counter: counts 0..SAMPLE_TICKS-1 while enable=1 and asserts a tick on the terminal count. It holds at 0 while enable=0. A sequence already in progress always completes.
- Trigger = tick OR sample_req.
  - In IDLE, a trigger moves the FSM to LATCH on the next edge.
  - A trigger while busy is dropped and sets overrun=1.
  - overrun_clr clears overrun unless an overrun event occurs in the same cycle; the event wins.
- FSM: IDLE -> LATCH -> VEL (NUM_ENC cycles, index 0..NUM_ENC-1) -> DISP0 -> DISP1 -> DONE -> IDLE.
  - LATCH: all channels of pos_flat are captured into an internal snapshot in the same cycle. If zero_pending, offsets are set to the snapshot and zero_pending clears.
  - VEL[i]: shared subtractor computes snap[i]-prev[i] modulo 2^32 (natural wrap); prev[i] <= snap[i]. If first_sample=1, the velocity is forced to 0.
  - DISP0: shared multiplier computes K0*(snap0-off0) into an accumulator.
  - DISP1: accumulator minus K1*(snap1-off1). Result is truncated to 32 bits with two's-complement wrap; no saturation.
  - DONE: snap_flat, vel_flat and displacement update together; sample_valid=1 for this cycle; sample_seq increments; first_sample clears.
- Latency: trigger at cycle t gives sample_valid at cycle t+NUM_ENC+4 (t+6 for NUM_ENC=2). busy is high from t+1 through DONE inclusive.
- Outputs are stable between sample_valid pulses; intermediate values are never visible.
- zero_req:
  - It sets zero_pending in any state.
  - If it coincides with LATCH it is held for the next snapshot.
  - If it coincides with the trigger cycle, it applies to that sample.
  - Zeroing does not affect velocity.
- sample_req and tick in the same IDLE cycle produce one sequence, not an overrun.

Decomposition:
- Shared package quad_pkg holds:
  - the state enum (IDLE, LATCH, VEL, DISP0, DISP1, DONE);
  - POS_W=32 and SEQ_W=16;
  - default K0/K1 constants.
- One natural sub-module: quad_sample_timer, containing the period counter plus enable gating and tick generation.
- The FSM and shared arithmetic stay in the top module.

Test Plan:
- Reset, enable=1, SAMPLE_TICKS=16, pos={100,50} held -> first sample_valid at cycle 16+6; vel={0,0}; displacement=225*100-424*50=1300; sample_seq=1.
- Next period with pos={110,45} -> vel={10,-5}; displacement=225*110-424*45=5670; sample_seq=2.
- pos0 steps 0x7FFFFFFF -> 0x80000000 between samples -> vel0 = +1 (wrap handled).
- zero_req pulse mid-period with pos={110,45} -> next sample displacement=0; vel unchanged; the following sample with pos={111,45} gives 225.
- sample_req pulsed during VEL state -> no extra sequence; overrun=1 and remains 1; overrun_clr -> 0.
- reset asserted in DISP0 -> no sample_valid; all outputs 0 on the next cycle; the first sample after reset reports vel=0.
